// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-N-1 UART transmitter, one byte per start pulse, done pulse after stop.
// Optional even parity bit between D7 and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rs232_tx,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  // rs232_tx is updated on the same edge as the state so the line is a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rs232_tx   <= 1'b1;
      done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= START;
            rs232_tx   <= 1'b0;
            shift      <= data;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
          end
        end
        default: begin
          if (baud_cnt != BIT_END) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            case (state)
              START: begin
                state    <= DATA;
                rs232_tx <= shift[0];
              end
              DATA: begin
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state    <= PARITY;
                  rs232_tx <= parity_bit;
`else
                  state    <= STOP;
                  rs232_tx <= 1'b1;
`endif
                end else begin
                  bit_cnt  <= bit_cnt + 3'd1;
                  shift    <= shift >> 1;
                  rs232_tx <= shift[1];
                end
              end
`ifdef UART_TX_PARITY_EN
              PARITY: begin
                state    <= STOP;
                rs232_tx <= 1'b1;
              end
`endif
              STOP: begin
                state    <= IDLE;
                rs232_tx <= 1'b1;
                done     <= 1'b1;
              end
              default: begin
                state    <= IDLE;
                rs232_tx <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (table vectors, corner sequences, random frames).
module tb_uart_tx;

  localparam int BD = 100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rs232_tx;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic [9:0] seq;   // 8-N-1 line sequence, leftmost = start bit
    logic       par;   // expected even-parity bit
    string      name;
  } vec_t;

  vec_t vecs[4];

  uart_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data    (data),
    .rs232_tx(rs232_tx),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] table_bits(input logic [9:0] seq, input logic par);
    logic [10:0] b;
    b = '1;
    for (int k = 0; k < 9; k++) b[k] = seq[9-k];
`ifdef UART_TX_PARITY_EN
    b[9]  = par;
    b[10] = 1'b1;
`else
    b[9]  = seq[0];
`endif
    return b;
  endfunction

  function automatic logic [10:0] model_bits(input logic [7:0] d);
    logic [10:0] b;
    int ones;
    b    = '1;
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[1+i] = (((d >> i) & 8'h01) != 0);
      if (b[1+i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    b[9] = (ones % 2) == 1;
`endif
    b[NB-1] = 1'b1;
    return b;
  endfunction

  task automatic idle_check(input int n, input string name);
    logic got_tx, got_done;
    got_tx   = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rs232_tx !== 1'b1) got_tx = rs232_tx;
      if (done !== 1'b0) got_done = done;
    end
    chk({name, "_tx"}, got_tx, 1'b1);
    chk({name, "_done"}, got_done, 1'b0);
  endtask

  // Called at a negedge; start is accepted on the following posedge (E0).
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input string name,
                           input bit inject);
    logic got;
    logic early;
    int   j;
    start = 1'b1;
    data  = d;
    @(posedge clk);
    early = 1'b0;
    j = 0;
    for (int k = 0; k < NB; k++) begin
      got = exp[k];
      for (int s = 0; s < BD; s++) begin
        @(negedge clk);
        if (j == 0) start = 1'b0;
        if (inject && j == 300) begin
          start = 1'b1;
          data  = ~d;
        end
        if (inject && j == 301) start = 1'b0;
        if (rs232_tx !== exp[k]) got = rs232_tx;
        if (done !== 1'b0) early = 1'b1;
        j++;
      end
      chk($sformatf("%s_bit%0d", name, k), got, exp[k]);
    end
    chk({name, "_done_early"}, early, 1'b0);
    @(negedge clk);
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_stop_idle"}, rs232_tx, 1'b1);
  endtask

  initial begin
    logic [7:0] rd;
    int gap;

    vecs[0] = '{d: 8'h55, seq: 10'b0101010101, par: 1'b0, name: "v55"};
    vecs[1] = '{d: 8'h58, seq: 10'b0000110101, par: 1'b1, name: "v58"};
    vecs[2] = '{d: 8'hB8, seq: 10'b0000111011, par: 1'b0, name: "vB8"};
    vecs[3] = '{d: 8'hA5, seq: 10'b0101001011, par: 1'b0, name: "vA5"};

    #50;
    chk("reset_tx", rs232_tx, 1'b1);
    chk("reset_done", done, 1'b0);
    #50 rst_n = 1'b1;
    idle_check(200, "post_reset");

    // Table frames run back-to-back: each next start lands in the done cycle.
    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].d, table_bits(vecs[i].seq, vecs[i].par), vecs[i].name, 1'b0);
    idle_check(20, "after_table");

    // Start pulse and data change mid-frame must not disturb anything.
    run_frame(8'h55, model_bits(8'h55), "inject", 1'b1);
    idle_check(1200, "no_second_frame");

    // Reset in the middle of the 4th data bit.
    start = 1'b1;
    data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4 * BD + 50) @(negedge clk);
    chk("pre_reset_tx", rs232_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", rs232_tx, 1'b1);
    chk("async_reset_done", done, 1'b0);
    idle_check(10, "in_reset");
    rst_n = 1'b1;
    idle_check(1200, "no_resume");
    run_frame(8'hA5, table_bits(vecs[3].seq, vecs[3].par), "post_rst_A5", 1'b0);

    for (int i = 0; i < 8; i++) begin
      rd  = 8'($urandom);
      gap = $urandom_range(0, 15);
      if (gap > 0) idle_check(gap, $sformatf("gap%0d", i));
      run_frame(rd, model_bits(rd), $sformatf("rnd%0d_%02h", i, rd), 1'b0);
    end
    idle_check(5, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
